control_config_loader: RTL and testbench

- Configuration loader that sits directly upstream of control_connection_block.
- Accepts a word-serial configuration stream on a valid/ready interface.
- Assembles the words into a CONF_WIDTH-bit word and verifies an XOR checksum.
- On success, presents the word on c and pulses cset for exactly one cycle so the connection block latches it. One instance per connection block, in the fabric configuration chain.

---
 rtl/control_config_loader.sv | 123 ++++++++++++
 tb/tb_control_config_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/control_config_loader.sv
// Word-serial configuration loader: assembles a CONF_WIDTH-bit word from a
// valid/ready stream, verifies an XOR checksum and commits it with a cset strobe.
module control_config_loader #(
  parameter int unsigned W          = 8,
  parameter int unsigned CONTROLIN  = 6,
  parameter int unsigned SEL_PER_IN = $clog2(W * 2),
  parameter int unsigned CONF_WIDTH = SEL_PER_IN * CONTROLIN,
  parameter int unsigned DW         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DW-1:0]         cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic [CONF_WIDTH-1:0] c,
  output logic                  cset,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned NWORDS = (CONF_WIDTH + DW - 1) / DW;
  localparam int unsigned CW     = $clog2(NWORDS + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  localparam logic [CONF_WIDTH-1:0] WORD_MASK = CONF_WIDTH'({DW{1'b1}});

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         acc_q, acc_d;
  logic [CONF_WIDTH-1:0] shadow_q, shadow_d;
  logic                  err_q, err_d;
  logic                  cset_q, done_q, busy_q;
  logic                  xfer;
  logic [31:0]           word_shift;

  assign cfg_ready  = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign xfer       = cfg_valid && cfg_ready;
  assign word_shift = DW * 32'(cnt_q);

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    shadow_d = shadow_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          cnt_d    = '0;
          acc_d    = '0;
          shadow_d = '0;
          err_d    = 1'b0;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          // Bits shifted past CONF_WIDTH fall off; the checksum still sees them
          shadow_d = (shadow_q & ~(WORD_MASK << word_shift))
                   | (CONF_WIDTH'(cfg_data) << word_shift);
          acc_d    = acc_q ^ cfg_data;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(NWORDS - 1)) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          if (cfg_data == acc_q) begin
            state_d = S_COMMIT;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      shadow_q <= '0;
      err_q    <= 1'b0;
      cset_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
      cset_q   <= (state_d == S_COMMIT);
      done_q   <= (state_d == S_COMMIT);
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign c    = shadow_q;
  assign cset = cset_q;
  assign done = done_q;
  assign busy = busy_q;
  assign err  = err_q;

endmodule

// File: tb/tb_control_config_loader.sv
// Scoreboard bench: two loaders (24-bit default and 20-bit) share one stream;
// expected commit words are queued by the driver and checked on each cset.
module tb_control_config_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        cfg_valid;
  logic [7:0]  cfg_data;

  logic        ready0, cset0, busy0, done0, err0;
  logic [23:0] c0;
  logic        ready1, cset1, busy1, done1, err1;
  logic [19:0] c1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [23:0] q0[$];
  logic [19:0] q1[$];

  control_config_loader dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready0),
    .c(c0), .cset(cset0), .busy(busy0), .done(done0), .err(err0)
  );

  control_config_loader #(.CONF_WIDTH(20)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready1),
    .c(c1), .cset(cset1), .busy(busy1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every commit must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst && (cset0 || done0)) begin
      check("done_eq_cset0", 32'(done0), 32'(cset0));
      if (cset0) begin
        check("cset0_expected", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) check("c0_commit", 32'(c0), 32'(q0.pop_front()));
      end
    end
    if (rst && (cset1 || done1)) begin
      check("done_eq_cset1", 32'(done1), 32'(cset1));
      if (cset1) begin
        check("cset1_expected", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) check("c1_commit", 32'(c1), 32'(q1.pop_front()));
      end
    end
  end

  // Present one word after nstall idle cycles and hold it until accepted
  task automatic send_word(input logic [7:0] d, input int nstall, input bit with_abort);
    int guard;
    bit rdy;
    cfg_valid = 1'b0;
    repeat (nstall) tick();
    cfg_data  = d;
    cfg_valid = 1'b1;
    abort     = with_abort;
    guard     = 0;
    do begin
      rdy = ready0;
      tick();
      guard++;
    end while (!rdy && guard < 16);
    if (!rdy) check("xfer_timeout", 32'(rdy), 32'd1);
    cfg_valid = 1'b0;
    abort     = 1'b0;
  endtask

  // stall < 0 picks random gaps; abort_at in 0..3 aborts on that word
  task automatic run_load(input logic [7:0] w [4], input int stall, input int abort_at,
                          input bit mid_start, input bit start_abort);
    logic [7:0]  xsum;
    logic [31:0] full;
    bit          ok;
    xsum = w[0] ^ w[1] ^ w[2];
    ok   = (w[3] == xsum);
    full = {8'h00, w[2], w[1], w[0]};
    start = 1'b1;
    abort = start_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("err_cleared_on_start", 32'(err0), 32'd0);
    check("busy_after_start", 32'(busy0), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k == abort_at) begin
        send_word(w[k], (stall < 0) ? int'($urandom_range(0, 3)) : stall, 1'b1);
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_no_cset", 32'(cset0), 32'd0);
        check("abort_err", 32'(err0), 32'd0);
        return;
      end
      if (k == 3 && ok) begin
        q0.push_back(full[23:0]);
        q1.push_back(full[19:0]);
      end
      send_word(w[k], (stall < 0) ? int'($urandom_range(0, 3)) : ((k == 0) ? 0 : stall), 1'b0);
      if (k == 0 && mid_start) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        check("mid_start_busy", 32'(busy0), 32'd1);
      end
    end
    if (ok) begin
      check("cset_at_commit", 32'(cset0), 32'd1);
      check("cset1_at_commit", 32'(cset1), 32'd1);
      check("busy_in_commit", 32'(busy0), 32'd1);
      tick();
      check("cset_one_cycle", 32'(cset0), 32'd0);
      check("busy_after_commit", 32'(busy0), 32'd0);
      check("c0_hold", 32'(c0), 32'(full[23:0]));
    end else begin
      check("bad_err0", 32'(err0), 32'd1);
      check("bad_err1", 32'(err1), 32'd1);
      check("bad_busy", 32'(busy0), 32'd0);
      check("bad_no_cset", 32'(cset0), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w [4];
    rst = 1'b0; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
    tick(); tick();
    rst = 1'b1;
    tick();
    check("rst_ready", 32'(ready0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_c", 32'(c0), 32'd0);

    // Nominal load, no stalls
    w = '{8'h21, 8'h43, 8'h65, 8'h07};
    run_load(w, 0, -1, 1'b0, 1'b0);

    // Back-pressure: two idle cycles between words
    run_load(w, 2, -1, 1'b0, 1'b0);

    // Bad checksum, then a good load clears err and commits
    w = '{8'h21, 8'h43, 8'h65, 8'h08};
    run_load(w, 0, -1, 1'b0, 1'b0);
    w = '{8'h21, 8'h43, 8'h65, 8'h07};
    run_load(w, 0, -1, 1'b0, 1'b0);

    // Abort coincident with the second data word
    run_load(w, 0, 1, 1'b0, 1'b0);
    tick();
    check("abort_no_late_cset", 32'(cset0), 32'd0);

    // start in LOAD ignored; start with abort in IDLE honoured
    w = '{8'h12, 8'h34, 8'h56, 8'h12 ^ 8'h34 ^ 8'h56};
    run_load(w, 0, -1, 1'b1, 1'b1);

    // All-ones: the 20-bit instance drops the top nibble
    w = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_load(w, 0, -1, 1'b0, 1'b0);
    check("c1_truncated", 32'(c1), 32'h000FFFFF);

    // Reset mid-load: everything discarded, no commit
    w = '{8'hA5, 8'h5A, 8'h3C, 8'hC3};
    start = 1'b1; tick(); start = 1'b0;
    send_word(8'hA5, 0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy0), 32'd0);
    check("async_rst_ready", 32'(ready0), 32'd0);
    tick();
    rst = 1'b1;
    check("rst_mid_c", 32'(c0), 32'd0);
    check("rst_mid_cset", 32'(cset0), 32'd0);
    check("rst_mid_err", 32'(err0), 32'd0);
    check("rst_mid_ready", 32'(ready0), 32'd0);
    check("rst_mid_busy", 32'(busy0), 32'd0);
    tick();

    // Randomized loads: stalls, corrupt checksums, aborts
    for (int n = 0; n < 40; n++) begin
      logic [7:0] x;
      int ab;
      w[0] = 8'($urandom); w[1] = 8'($urandom); w[2] = 8'($urandom);
      x = w[0] ^ w[1] ^ w[2];
      w[3] = ($urandom_range(0, 3) == 0) ? (x ^ 8'($urandom_range(1, 255))) : x;
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_load(w, -1, ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    check("scoreboard0_drained", 32'(q0.size()), 32'd0);
    check("scoreboard1_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
